// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_bus_arbiter : two-master round-robin Wishbone arbiter with bus lock.
//                  Optional stall watchdog enabled by macro WB_ARB_TIMEOUT_EN.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int AW             = 24,
  parameter int DW             = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DW-1:0]     m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DW-1:0]     m1_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic [DW-1:0]     s_dat_i,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   g_cyc, g_stb;
  logic   tmo_hit;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0:    if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0)      last_gnt_d = 1'b0;
    else if (state_d == GNT1) last_gnt_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state_q)
      GNT0: begin
        g_cyc = m0_cyc_i; g_stb = m0_stb_i; s_we_o = m0_we_i;
        s_sel_o = m0_sel_i; s_adr_o = m0_adr_i; s_dat_o = m0_dat_i;
      end
      GNT1: begin
        g_cyc = m1_cyc_i; g_stb = m1_stb_i; s_we_o = m1_we_i;
        s_sel_o = m1_sel_i; s_adr_o = m1_adr_i; s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign s_cyc_o = g_cyc & ~tmo_hit;
  assign s_stb_o = g_stb & ~tmo_hit;

  // Gating with the owner's cyc discards an ack arriving as the master lets go.
  assign m0_ack_o = (state_q == GNT0) & g_cyc & s_ack_i & ~tmo_hit;
  assign m1_ack_o = (state_q == GNT1) & g_cyc & s_ack_i & ~tmo_hit;
  assign m0_err_o = (state_q == GNT0) & ((g_cyc & s_err_i) | tmo_hit);
  assign m1_err_o = (state_q == GNT1) & ((g_cyc & s_err_i) | tmo_hit);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = state_q;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 16'd1;
    if (tmo_hit || (state_d != state_q) || !(g_cyc && g_stb) || s_ack_i || s_err_i)
      tmo_cnt_d = '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign tmo_hit            = 1'b0;
`endif

  assign timeout_o = tmo_hit;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// tb_wb_bus_arbiter : directed arbitration scenarios plus randomized two-master
// traffic, checked by a grant model and request/response scoreboards.
module tb_wb_bus_arbiter;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [SW-1:0] m_sel [2];
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          s_cyc, s_stb, s_we;
  logic [SW-1:0] s_sel;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic          s_ack, s_err;
  logic [DW-1:0] s_rdat;
  logic [1:0]    gnt;
  logic          tmo;

  wb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
    .m0_sel_i(m_sel[0]), .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
    .m1_sel_i(m_sel[1]), .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_rdat),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;

  req_t req_q0[$], req_q1[$];
  rsp_t rsp_q0[$], rsp_q1[$];
  int   glog[$];
  int   ack_log[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Environment knobs written by the main sequence only.
  int            slave_mode   = 0;   // 0 normal, 1 never responds, 2 bench-forced ack
  int            fixed_lat    = 0;
  bit            rand_lat     = 1'b0;
  bit            err_en       = 1'b0;
  bit            force_dat_en = 1'b0;
  logic [DW-1:0] force_dat    = '0;
  bit            force_ack    = 1'b0;
  bit            tmo_window   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no matching DUT event, expected one", name);
  endtask

  // ---------------- master side ----------------
  task automatic drive_beat(input int m, input bit rnd);
    req_t r;
    r.we  = rnd ? 1'($urandom) : 1'b0;
    r.sel = rnd ? SW'($urandom) : '1;
    r.adr = AW'($urandom);
    r.adr[AW-1] = 1'(m);
    r.dat = DW'($urandom);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = r.we;
    m_sel[m] = r.sel; m_adr[m] = r.adr; m_dat[m] = r.dat;
    if (m == 0) req_q0.push_back(r);
    else        req_q1.push_back(r);
  endtask

  task automatic wait_term(input int m);
    int budget = 60;
    bit done   = 1'b0;
    while (!done && budget > 0) begin
      @(negedge clk); #2;
      done = (m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
      budget--;
    end
    if (!done) fail_now($sformatf("m%0d_term_wait", m));
  endtask

  task automatic do_txn(input int m, input int beats, input int gap, input bit rnd);
    for (int b = 0; b < beats; b++) begin
      @(posedge clk); #1;
      drive_beat(m, rnd);
      wait_term(m);
    end
    @(posedge clk); #1;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // ---------------- slave model ----------------
  initial begin
    int   wcnt = 0;
    int   lim  = 0;
    int   id;
    req_t r;
    rsp_t rs;
    s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
    forever begin
      @(posedge clk); #1;
      s_ack = (slave_mode == 2) ? force_ack : 1'b0;
      s_err = 1'b0;
      @(negedge clk);
      if (slave_mode == 0 && !rst && s_cyc && s_stb) begin
        if (wcnt >= (rand_lat ? lim : fixed_lat)) begin
          wcnt = 0;
          lim  = $urandom_range(0, 3);
          id   = int'(s_adr[AW-1]);
          if ((id == 0 && req_q0.size() == 0) || (id == 1 && req_q1.size() == 0)) begin
            fail_now("slave_unexpected_req");
          end else begin
            if (id == 0) r = req_q0.pop_front();
            else         r = req_q1.pop_front();
            chk("s_adr", 32'(s_adr), 32'(r.adr));
            chk("s_we",  32'(s_we),  32'(r.we));
            chk("s_sel", 32'(s_sel), 32'(r.sel));
            if (r.we) chk("s_dat", 32'(s_wdat), 32'(r.dat));
          end
          rs.err = err_en && ($urandom_range(0, 7) == 0);
          rs.dat = force_dat_en ? force_dat : DW'($urandom);
          s_rdat = rs.dat;
          s_ack  = ~rs.err;
          s_err  = rs.err;
          if (id == 0) rsp_q0.push_back(rs);
          else         rsp_q1.push_back(rs);
        end else begin
          wcnt++;
        end
      end else if (slave_mode == 0) begin
        wcnt = 0;
      end
    end
  end

  // ---------------- monitor: grant model + response scoreboard ----------------
  task automatic mon_master(input int m);
    logic          a, e;
    logic [DW-1:0] d;
    rsp_t          rs;
    a = (m == 0) ? m0_ack  : m1_ack;
    e = (m == 0) ? m0_err  : m1_err;
    d = (m == 0) ? m0_rdat : m1_rdat;
    if (a && e) begin
      chk($sformatf("m%0d_ack_err_both", m), 32'(e), 32'(0));
    end else if (a || e) begin
      if ((m == 0 && rsp_q0.size() == 0) || (m == 1 && rsp_q1.size() == 0)) begin
        fail_now($sformatf("m%0d_unexpected_term", m));
      end else begin
        if (m == 0) rs = rsp_q0.pop_front();
        else        rs = rsp_q1.pop_front();
        chk($sformatf("m%0d_err", m), 32'(e), 32'(rs.err));
        if (a) chk($sformatf("m%0d_dat", m), 32'(d), 32'(rs.dat));
        ack_log.push_back(m);
      end
    end
  endtask

  initial begin
    int         owner = -1;  // -1 = bus idle
    int         last  = 1;
    int         nxt;
    logic [1:0] prev_g = 2'b00;
    int         exp_g;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        owner = -1;
        last  = 1;
      end
      exp_g = (owner < 0) ? 0 : (owner == 0 ? 1 : 2);
      chk("gnt_o", 32'(gnt), 32'(exp_g));
      if (gnt != prev_g && gnt != 2'b00) glog.push_back(int'(gnt));
      prev_g = gnt;
      if (!tmo_window) begin
        chk("timeout_o", 32'(tmo), 32'(0));
        mon_master(0);
        mon_master(1);
      end
      if (!rst) begin
        if (owner >= 0 && m_cyc[owner])      nxt = owner;
        else if (owner >= 0)                 nxt = m_cyc[1-owner] ? 1 - owner : -1;
        else if (m_cyc[0] && m_cyc[1])       nxt = 1 - last;
        else if (m_cyc[0])                   nxt = 0;
        else if (m_cyc[1])                   nxt = 1;
        else                                 nxt = -1;
        if (nxt >= 0) last = nxt;
        owner = nxt;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_sel[i] = '0;   m_adr[i] = '0;   m_dat[i] = '0;
    end

    // Reset state
    @(negedge clk); #2;
    chk("rst_gnt",     32'(gnt),    32'(0));
    chk("rst_s_cyc",   32'(s_cyc),  32'(0));
    chk("rst_s_stb",   32'(s_stb),  32'(0));
    chk("rst_timeout", 32'(tmo),    32'(0));
    chk("rst_m0_ack",  32'(m0_ack), 32'(0));
    chk("rst_m1_ack",  32'(m1_ack), 32'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Single m0 read, slave answers two cycles after strobe with 0xBEEF
    fixed_lat = 2; force_dat_en = 1'b1; force_dat = 16'hBEEF;
    @(posedge clk); #1; drive_beat(0, 1'b0);
    @(negedge clk); #2;
    chk("read_gnt_same_cycle", 32'(gnt), 32'(0));
    @(negedge clk); #2;
    chk("read_gnt_next_cycle", 32'(gnt),   32'(1));
    chk("read_s_cyc",          32'(s_cyc), 32'(1));
    wait_term(0);
    chk("read_m0_ack", 32'(m0_ack),  32'(1));
    chk("read_m0_dat", 32'(m0_rdat), 32'hBEEF);
    chk("read_m1_ack", 32'(m1_ack),  32'(0));
    @(posedge clk); #1; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    force_dat_en = 1'b0;
    fixed_lat = 0;

    // Simultaneous request from reset: m0 first, then m1 with no idle gap
    do_reset();
    glog.delete();
    fork
      do_txn(0, 1, 0, 1'b0);
      do_txn(1, 1, 0, 1'b0);
    join
    repeat (3) @(posedge clk);
    chk("tie_glog_len", 32'(glog.size()), 32'(2));
    if (glog.size() == 2) begin
      chk("tie_first",  32'(glog[0]), 32'(1));
      chk("tie_second", 32'(glog[1]), 32'(2));
    end

    // Continuous requests alternate grants
    glog.delete();
    rand_lat = 1'b1;
    fork
      for (int i = 0; i < 4; i++) do_txn(0, 1, 0, 1'b0);
      for (int i = 0; i < 4; i++) do_txn(1, 1, 0, 1'b0);
    join
    repeat (3) @(posedge clk);
    chk("rr_glog_len", 32'(glog.size()), 32'(8));
    for (int i = 0; i < glog.size() && i < 8; i++)
      chk($sformatf("rr_grant_%0d", i), 32'(glog[i]), 32'((i % 2 == 0) ? 1 : 2));

    // m1 holds the bus across three beats while m0 waits
    glog.delete();
    ack_log.delete();
    fork
      do_txn(1, 3, 0, 1'b0);
      begin @(posedge clk); do_txn(0, 1, 0, 1'b0); end
    join
    repeat (3) @(posedge clk);
    chk("lock_glog_len", 32'(glog.size()), 32'(2));
    if (glog.size() == 2) begin
      chk("lock_first",  32'(glog[0]), 32'(2));
      chk("lock_second", 32'(glog[1]), 32'(1));
    end
    chk("lock_ack_len", 32'(ack_log.size()), 32'(4));
    for (int i = 0; i < ack_log.size() && i < 4; i++)
      chk($sformatf("lock_ack_%0d", i), 32'(ack_log[i]), 32'((i < 3) ? 1 : 0));
    rand_lat = 1'b0;

    // Stalled slave
    do_reset();
    slave_mode = 1;
    tmo_window = 1'b1;
    @(posedge clk); #1; drive_beat(0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk); #2;
      seen = s_stb;
    end
    if (!seen) fail_now("stall_stb_seen");
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #2;
      chk($sformatf("tmo_pulse_k%0d", k),  32'(tmo),    32'(k == TMO));
      chk($sformatf("tmo_m0_err_k%0d", k), 32'(m0_err), 32'(k == TMO));
      chk($sformatf("tmo_s_stb_k%0d", k),  32'(s_stb),  32'(k != TMO));
      chk($sformatf("tmo_m1_err_k%0d", k), 32'(m1_err), 32'(0));
    end
`else
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); #2;
      chk($sformatf("stall_m0_err_k%0d", k), 32'(m0_err), 32'(0));
      chk($sformatf("stall_tmo_k%0d", k),    32'(tmo),    32'(0));
      chk($sformatf("stall_s_stb_k%0d", k),  32'(s_stb),  32'(1));
    end
`endif

    // Master abandons the cycle while a late ack arrives
    slave_mode = 2;
    force_ack  = 1'b1;
    @(posedge clk); #1; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk); #2;
    chk("late_ack_m0", 32'(m0_ack), 32'(0));
    chk("late_ack_m1", 32'(m1_ack), 32'(0));
    force_ack = 1'b0;
    @(negedge clk); #2;
    chk("release_gnt", 32'(gnt), 32'(0));

    // Asynchronous reset in the middle of a stalled granted cycle
    slave_mode = 1;
    req_q0.delete();
    @(posedge clk); #1; drive_beat(0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    chk("arst_s_cyc", 32'(s_cyc), 32'(0));
    chk("arst_s_stb", 32'(s_stb), 32'(0));
    chk("arst_gnt",   32'(gnt),   32'(0));
    slave_mode = 2;
    force_ack  = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #2;
    chk("arst_ack_m0",  32'(m0_ack), 32'(0));
    chk("arst_ack_m1",  32'(m1_ack), 32'(0));
    chk("arst_timeout", 32'(tmo),    32'(0));
    force_ack  = 1'b0;
    slave_mode = 0;
    req_q0.delete();
    @(posedge clk); #1;
    tmo_window = 1'b0;

    // Randomized two-master traffic
    rand_lat = 1'b1;
    err_en   = 1'b1;
    fork
      for (int i = 0; i < 12; i++)
        do_txn(0, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b1);
      for (int i = 0; i < 12; i++)
        do_txn(1, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b1);
    join
    repeat (5) @(posedge clk);
    chk("end_req_q0", 32'(req_q0.size()), 32'(0));
    chk("end_req_q1", 32'(req_q1.size()), 32'(0));
    chk("end_rsp_q0", 32'(rsp_q0.size()), 32'(0));
    chk("end_rsp_q1", 32'(rsp_q1.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
